clk_edge_monitor: RTL and testbench

- Sits directly downstream of the clock divider in the same i_clk domain.
- Consumes the divided clock as a data signal: synchronises it, and turns its edges into single-cycle enable ticks for fabric logic.
- Measures each half-period in i_clk cycles and tracks lock/loss of the divided clock against an expected half-period.
- Logic downstream uses clock enables on i_clk instead of clocking from the divided clock.

---
 rtl/clk_edge_monitor_if.sv | 37 +++
 rtl/clk_edge_monitor.sv | 175 +++++++++++++++++
 tb/tb_clk_edge_monitor.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_edge_monitor_if.sv
// Signal bundle between the divided-clock monitor and its fabric user.
// The master drives the divided clock and controls; the slave is the monitor.
interface clk_edge_monitor_if;
    logic        i_div_clk;
    logic        i_enable;
    logic        i_err_clr;
    logic        o_rise_tick;
    logic        o_fall_tick;
    logic        o_locked;
    logic        o_lost;
    logic [15:0] o_half_period;
    logic [7:0]  o_err_cnt;

    modport master (
        output i_div_clk,
        output i_enable,
        output i_err_clr,
        input  o_rise_tick,
        input  o_fall_tick,
        input  o_locked,
        input  o_lost,
        input  o_half_period,
        input  o_err_cnt
    );

    modport slave (
        input  i_div_clk,
        input  i_enable,
        input  i_err_clr,
        output o_rise_tick,
        output o_fall_tick,
        output o_locked,
        output o_lost,
        output o_half_period,
        output o_err_cnt
    );
endinterface

// File: rtl/clk_edge_monitor.sv
// Samples a divided clock as data, emits edge ticks on i_clk and
// tracks half-period lock/loss against an expected half-period.
module clk_edge_monitor #(
    parameter int unsigned EXP_HALF    = 50,
    parameter int unsigned TOL         = 2,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TIMEOUT     = 100,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    clk_edge_monitor_if.slave mon
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);

    localparam logic [15:0]   MEAS_LO   = 16'(EXP_HALF - TOL);
    localparam logic [15:0]   MEAS_HI   = 16'(EXP_HALF + TOL);
    localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQUIRE,
        S_LOCKED,
        S_LOST
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [15:0]            cnt_q, cnt_d;
    logic                   first_q, first_d;
    logic [GW-1:0]          good_q, good_d;
    logic [15:0]            hp_q, hp_d;
    logic [7:0]             err_q, err_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    logic                   sync_lvl;
    logic                   edge_det;
    logic                   live;
    logic [15:0]            cnt_inc;
    logic                   meas_good;
    logic                   timeout;
    logic                   err_inc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon.i_div_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_lvl  = sync_q[SYNC_STAGES-1];
    assign edge_det  = sync_lvl ^ hist_q;
    assign live      = mon.i_enable && (state_q != S_IDLE);
    // Counter+1 doubles as the measurement: cycles since the last edge.
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign meas_good = (cnt_inc >= MEAS_LO) && (cnt_inc <= MEAS_HI);
    assign timeout   = (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        first_d = first_q;
        good_d  = good_q;
        hp_d    = hp_q;
        err_inc = 1'b0;
        rise_d  = live & edge_det & sync_lvl;
        fall_d  = live & edge_det & ~sync_lvl;

        if (!mon.i_enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_ACQUIRE;
                    first_d = 1'b1;
                    good_d  = '0;
                    cnt_d   = '0;
                end
                S_ACQUIRE: begin
                    if (edge_det) begin
                        cnt_d = '0;
                        if (first_q) begin
                            first_d = 1'b0;
                        end else begin
                            hp_d = cnt_inc;
                            if (!meas_good) begin
                                good_d = '0;
                            end else if (good_q == GOOD_LAST) begin
                                good_d  = '0;
                                state_d = S_LOCKED;
                            end else begin
                                good_d = good_q + GW'(1);
                            end
                        end
                    end else if (timeout) begin
                        state_d = S_LOST;
                    end
                end
                S_LOCKED: begin
                    if (edge_det) begin
                        cnt_d = '0;
                        hp_d  = cnt_inc;
                        if (!meas_good) begin
                            state_d = S_ACQUIRE;
                            good_d  = '0;
                            first_d = 1'b0;
                            err_inc = 1'b1;
                        end
                    end else if (timeout) begin
                        state_d = S_LOST;
                        err_inc = 1'b1;
                    end
                end
                S_LOST: begin
                    // The reviving edge only restarts the measurement.
                    if (edge_det) begin
                        cnt_d   = '0;
                        state_d = S_ACQUIRE;
                        first_d = 1'b0;
                        good_d  = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (mon.i_err_clr) begin
            err_d = '0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            good_q  <= '0;
            hp_q    <= '0;
            err_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            good_q  <= good_d;
            hp_q    <= hp_d;
            err_q   <= err_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign mon.o_rise_tick   = rise_q;
    assign mon.o_fall_tick   = fall_q;
    assign mon.o_locked      = (state_q == S_LOCKED);
    assign mon.o_lost        = (state_q == S_LOST);
    assign mon.o_half_period = hp_q;
    assign mon.o_err_cnt     = err_q;

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Self-checking bench for clk_edge_monitor: directed tables, corner
// sequences and random half-periods against an edge-timing model.
module tb_clk_edge_monitor;

    localparam int EXP_HALF = 50;
    localparam int TOL      = 2;
    localparam int LOCK_CNT = 4;
    localparam int TIMEOUT  = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    clk_edge_monitor_if mon_if ();

    clk_edge_monitor #(
        .EXP_HALF   (EXP_HALF),
        .TOL        (TOL),
        .LOCK_CNT   (LOCK_CNT),
        .TIMEOUT    (TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .mon      (mon_if)
    );

    always #5 clk = ~clk;

    int tests     = 0;
    int fails     = 0;
    int since_tog = 0;

    typedef enum int {M_IDLE, M_ACQ, M_LOCK, M_LOST} mst_e;

    mst_e        m_st;
    bit          m_first;
    int          m_streak;
    int          m_cyc = 0;
    int          m_last;
    bit [15:0]   m_hp;
    bit [7:0]    m_err;
    bit          m_rise;
    bit          m_fall;
    bit          samp[$];

    function automatic void model_reset();
        m_st     = M_IDLE;
        m_first  = 1'b0;
        m_streak = 0;
        m_last   = m_cyc;
        m_hp     = '0;
        m_err    = '0;
        m_rise   = 1'b0;
        m_fall   = 1'b0;
        samp     = '{1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    // Edge seen by the monitor = change in the input sampled two clocks ago.
    function automatic void model_update();
        bit ev, lvl, ok, inc;
        int gap;
        m_cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        samp.push_front(mon_if.i_div_clk);
        void'(samp.pop_back());
        ev     = samp[2] != samp[3];
        lvl    = samp[2];
        gap    = m_cyc - m_last;
        if (gap > 65535) gap = 65535;
        inc    = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (!mon_if.i_enable) begin
            m_st = M_IDLE;
        end else if (m_st == M_IDLE) begin
            m_st     = M_ACQ;
            m_first  = 1'b1;
            m_streak = 0;
            m_last   = m_cyc;
        end else if (ev) begin
            m_rise = lvl;
            m_fall = !lvl;
            if (m_st == M_LOST || (m_st == M_ACQ && m_first)) begin
                m_st     = M_ACQ;
                m_first  = 1'b0;
                m_streak = 0;
            end else begin
                ok   = (gap >= EXP_HALF - TOL) && (gap <= EXP_HALF + TOL);
                m_hp = gap[15:0];
                if (m_st == M_LOCK) begin
                    if (!ok) begin
                        m_st     = M_ACQ;
                        m_streak = 0;
                        inc      = 1'b1;
                    end
                end else if (ok) begin
                    m_streak++;
                    if (m_streak == LOCK_CNT) m_st = M_LOCK;
                end else begin
                    m_streak = 0;
                end
            end
            m_last = m_cyc;
        end else if (gap == TIMEOUT && (m_st == M_ACQ || m_st == M_LOCK)) begin
            if (m_st == M_LOCK) inc = 1'b1;
            m_st = M_LOST;
        end
        if (mon_if.i_err_clr) m_err = '0;
        else if (inc && m_err != 8'd255) m_err = m_err + 8'd1;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {4'b0, mon_if.o_rise_tick, mon_if.o_fall_tick,
                mon_if.o_locked, mon_if.o_lost,
                mon_if.o_half_period, mon_if.o_err_cnt};
    endfunction

    function automatic logic [31:0] model_vec();
        return {4'b0, m_rise, m_fall, m_st == M_LOCK, m_st == M_LOST,
                m_hp, m_err};
    endfunction

    function automatic logic tick();
        return mon_if.o_rise_tick | mon_if.o_fall_tick;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        since_tog++;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic toggle();
        mon_if.i_div_clk = ~mon_if.i_div_clk;
        since_tog = 0;
    endtask

    // Toggle n cycles after the previous toggle; return in the tick cycle.
    task automatic edge_after(input int n, output logic pre);
        while (since_tog < n) step();
        toggle();
        step();
        step();
        pre = tick();
        step();
    endtask

    task automatic chk_tick(input string name);
        chk(name, {mon_if.o_rise_tick, mon_if.o_fall_tick},
            {mon_if.i_div_clk, ~mon_if.i_div_clk});
    endtask

    typedef struct {
        int   hp;
        logic locked;
        logic lost;
        int   err;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pre;
        int   ticks;

        tbl[0]  = '{48,  1'b1, 1'b0, 0};
        tbl[1]  = '{52,  1'b1, 1'b0, 0};
        tbl[2]  = '{50,  1'b1, 1'b0, 0};
        tbl[3]  = '{47,  1'b0, 1'b0, 1};
        tbl[4]  = '{50,  1'b0, 1'b0, 1};
        tbl[5]  = '{50,  1'b0, 1'b0, 1};
        tbl[6]  = '{50,  1'b0, 1'b0, 1};
        tbl[7]  = '{50,  1'b1, 1'b0, 1};
        tbl[8]  = '{53,  1'b0, 1'b0, 2};
        tbl[9]  = '{48,  1'b0, 1'b0, 2};
        tbl[10] = '{52,  1'b0, 1'b0, 2};
        tbl[11] = '{48,  1'b0, 1'b0, 2};
        tbl[12] = '{52,  1'b1, 1'b0, 2};
        tbl[13] = '{100, 1'b0, 1'b0, 3};
        tbl[14] = '{50,  1'b0, 1'b0, 3};
        tbl[15] = '{50,  1'b0, 1'b0, 3};
        tbl[16] = '{50,  1'b0, 1'b0, 3};
        tbl[17] = '{50,  1'b1, 1'b0, 3};

        mon_if.i_div_clk = 1'b0;
        mon_if.i_enable  = 1'b0;
        mon_if.i_err_clr = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_outputs", dut_vec(), 32'd0);

        // Bring-up with a steady 50-cycle half-period.
        rst_n = 1'b1;
        mon_if.i_enable = 1'b1;
        repeat (2) step();
        for (int e = 1; e <= 6; e++) begin
            edge_after(50, pre);
            chk("tick_latency", pre, 1'b0);
            chk_tick("tick_level");
            chk("lock_on_5th", mon_if.o_locked, e >= 5);
            if (e >= 2) chk("half_50", mon_if.o_half_period, 16'd50);
            chk("err_zero", mon_if.o_err_cnt, 8'd0);
            step();
            chk("tick_width", tick(), 1'b0);
        end

        // Tolerance boundaries, relock and edge-at-timeout.
        for (int i = 0; i < 18; i++) begin
            edge_after(tbl[i].hp, pre);
            chk_tick("tbl_tick");
            chk("tbl_locked", mon_if.o_locked, tbl[i].locked);
            chk("tbl_lost", mon_if.o_lost, tbl[i].lost);
            chk("tbl_half", mon_if.o_half_period, 16'(tbl[i].hp));
            chk("tbl_err", mon_if.o_err_cnt, 8'(tbl[i].err));
        end

        // Static divided clock while locked.
        repeat (99) step();
        chk("lost_before", mon_if.o_lost, 1'b0);
        step();
        chk("lost_at_100", {mon_if.o_lost, mon_if.o_locked}, 2'b10);
        chk("lost_err", mon_if.o_err_cnt, 8'd4);
        edge_after(50, pre);
        chk("revive_lost", mon_if.o_lost, 1'b0);
        chk_tick("revive_tick");
        for (int e = 2; e <= 5; e++) begin
            edge_after(50, pre);
            chk("relock", mon_if.o_locked, e == 5);
        end

        // Enable dropped in the same cycle as an edge.
        while (since_tog < 47) step();
        toggle();
        step();
        step();
        mon_if.i_enable = 1'b0;
        step();
        chk("idle_edge_tick", tick(), 1'b0);
        chk("idle_locked", mon_if.o_locked, 1'b0);
        ticks = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 20 == 10) toggle();
            step();
            ticks += int'(tick());
        end
        chk("idle_ticks", ticks, 0);
        chk("idle_half", mon_if.o_half_period, 16'd50);
        chk("idle_err", mon_if.o_err_cnt, 8'd4);
        mon_if.i_enable = 1'b1;
        for (int e = 1; e <= 5; e++) edge_after(50, pre);
        chk("locked_again", mon_if.o_locked, 1'b1);

        // Asynchronous reset between clock edges.
        rst_n = 1'b0;
        #1;
        chk("async_reset", dut_vec(), 32'd0);
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) edge_after(50, pre);
        chk("locked_post_rst", mon_if.o_locked, 1'b1);

        // 260 lock losses saturate the error counter.
        for (int i = 0; i < 260; i++) begin
            repeat (4) edge_after(48, pre);
            edge_after(10, pre);
            if (i == 254) chk("err_255", mon_if.o_err_cnt, 8'd255);
        end
        chk("err_sat", mon_if.o_err_cnt, 8'd255);

        // Clear coinciding with a lock loss.
        repeat (4) edge_after(48, pre);
        chk("locked_pre_clr", mon_if.o_locked, 1'b1);
        while (since_tog < 10) step();
        toggle();
        step();
        step();
        mon_if.i_err_clr = 1'b1;
        step();
        mon_if.i_err_clr = 1'b0;
        chk("clr_wins", mon_if.o_err_cnt, 8'd0);
        chk("clr_unlock", mon_if.o_locked, 1'b0);

        // Random half-periods, enable gaps and clears.
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                edge_after(int'($urandom_range(47, 53)), pre);
            end else if (r < 7) begin
                edge_after(int'($urandom_range(4, 46)), pre);
            end else if (r == 7) begin
                edge_after(int'($urandom_range(54, 130)), pre);
            end else if (r == 8) begin
                mon_if.i_err_clr = 1'b1;
                step();
                mon_if.i_err_clr = 1'b0;
                edge_after(50, pre);
            end else begin
                mon_if.i_enable = 1'b0;
                repeat (int'($urandom_range(1, 30))) step();
                mon_if.i_enable = 1'b1;
                edge_after(50, pre);
            end
        end
        repeat (5) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
